// File: rtl/vote_button_control.sv
// -----------------------------------------------------------------------------
// vote_button_control
// Front-end stage for the vote logger. Conditions four raw candidate buttons
// (2-flop synchroniser, counter debounce, rising-edge detect) and enforces one
// vote per armed ballot, emitting clean single-cycle cand*_vote_valid pulses.
//
// Ports
//   clock            in  system clock, all logic on posedge
//   reset_n          in  asynchronous active-low reset
//   mode             in  0 = voting, 1 = result display (ballots disabled)
//   arm              in  official ballot-enable level; a 0->1 edge arms
//   btn1..btn4       in  raw asynchronous candidate buttons, active-high
//   cand1..4_vote_valid out  one-cycle vote pulse per candidate
//   ballot_ready     out high while armed and awaiting a vote
//   vote_cast_led    out high from the vote pulse until all buttons released
//   conflict_err     out one-cycle pulse on simultaneous presses while armed
// -----------------------------------------------------------------------------
module vote_button_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic mode,
  input  logic arm,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  input  logic btn4,
  output logic cand1_vote_valid,
  output logic cand2_vote_valid,
  output logic cand3_vote_valid,
  output logic cand4_vote_valid,
  output logic ballot_ready,
  output logic vote_cast_led,
  output logic conflict_err
);

  localparam int unsigned NB = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAST    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [NB-1:0]    w_btn_raw;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_deb;
  logic [NB-1:0]    r_deb_d;
  logic [CNT_W-1:0] r_cnt [NB];
  logic             r_arm_d;

  logic [NB-1:0]    w_press;
  logic             w_arm_rise;
  logic             w_one_press;
  logic             w_multi_press;

  state_t           r_state;
  state_t           w_next;
  logic [NB-1:0]    r_valid;
  logic [NB-1:0]    w_valid_next;
  logic             r_ready;
  logic             w_ready_next;
  logic             r_led;
  logic             w_led_next;
  logic             r_conf;
  logic             w_conf_next;

  assign w_btn_raw = {btn4, btn3, btn2, btn1};

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count cycles of disagreement; accept the new level once the
  // counter has reached DEBOUNCE_CYCLES and the input still disagrees.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int k = 0; k < int'(NB); k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_deb_d <= r_deb;
      for (int k = 0; k < int'(NB); k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_W'(DEBOUNCE_CYCLES)) begin
          r_deb[k] <= r_sync2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Arm edge detector
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_d <= 1'b0;
    end else begin
      r_arm_d <= arm;
    end
  end

  assign w_press       = r_deb & ~r_deb_d;
  assign w_arm_rise    = arm & ~r_arm_d;
  // Clearing the lowest set bit leaves zero only when at most one bit is set
  assign w_multi_press = (w_press & (w_press - NB'(1))) != '0;
  assign w_one_press   = (w_press != '0) && !w_multi_press;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_ready <= 1'b0;
      r_led   <= 1'b0;
      r_conf  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_valid_next;
      r_ready <= w_ready_next;
      r_led   <= w_led_next;
      r_conf  <= w_conf_next;
    end
  end

  // Ballot FSM; r_valid holds the one-hot candidate latched on the cast edge
  always_comb begin
    w_next       = r_state;
    w_valid_next = '0;
    w_conf_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm_rise && !mode) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (mode) begin
          w_next = S_IDLE;
        end else if (w_one_press) begin
          w_next       = S_CAST;
          w_valid_next = w_press;
        end else if (w_multi_press) begin
          w_conf_next = 1'b1;
        end
      end
      S_CAST: begin
        w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (r_deb == '0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    w_ready_next = (w_next == S_ARMED);
    w_led_next   = (w_next == S_CAST) || (w_next == S_RELEASE);
  end

  assign cand1_vote_valid = r_valid[0];
  assign cand2_vote_valid = r_valid[1];
  assign cand3_vote_valid = r_valid[2];
  assign cand4_vote_valid = r_valid[3];
  assign ballot_ready     = r_ready;
  assign vote_cast_led    = r_led;
  assign conflict_err     = r_conf;

endmodule

// File: tb/tb_vote_button_control.sv
// -----------------------------------------------------------------------------
// tb_vote_button_control
// Self-checking bench: table vectors, hand-written corner sequences and a
// randomized phase, all compared cycle by cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_vote_button_control;

  localparam int unsigned D = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mode;
  logic       arm;
  logic [3:0] btn;
  logic       cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid;
  logic       ballot_ready, vote_cast_led, conflict_err;
  logic [3:0] w_valid;

  always #5 clock = ~clock;

  vote_button_control #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .mode             (mode),
    .arm              (arm),
    .btn1             (btn[0]),
    .btn2             (btn[1]),
    .btn3             (btn[2]),
    .btn4             (btn[3]),
    .cand1_vote_valid (cand1_vote_valid),
    .cand2_vote_valid (cand2_vote_valid),
    .cand3_vote_valid (cand3_vote_valid),
    .cand4_vote_valid (cand4_vote_valid),
    .ballot_ready     (ballot_ready),
    .vote_cast_led    (vote_cast_led),
    .conflict_err     (conflict_err)
  );

  assign w_valid = {cand4_vote_valid, cand3_vote_valid, cand2_vote_valid, cand1_vote_valid};

  int n_checks = 0;
  int n_fail   = 0;
  int p_cnt [4];
  int p_conf;

  // Behavioural model state
  logic [3:0] hist [$];   // raw button samples, index 0 = newest
  logic [3:0] m_deb;
  logic [3:0] m_press;
  bit         m_prev_arm;
  bit         m_armed, m_cast, m_locked;
  logic [3:0] e_valid;
  bit         e_ready, e_led, e_conf;

  typedef struct {
    bit         do_arm;
    bit         mode_v;
    logic [3:0] mask;
    int         hold;
    logic [3:0] exp_cand;
    int         exp_conf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < int'(D) + 3; i++) hist.push_back(4'b0);
    m_deb = '0; m_press = '0; m_prev_arm = 0;
    m_armed = 0; m_cast = 0; m_locked = 0;
    e_valid = '0; e_ready = 0; e_led = 0; e_conf = 0;
  endtask

  // One clock of the reference: ballot rules first (on the previous cycle's
  // press events and debounced levels), then button conditioning.
  task automatic model_step();
    logic [3:0] p;
    int         np;
    bit         rise;
    logic [3:0] nd;
    bit         all_diff;
    p    = m_press;
    np   = $countones(p);
    rise = arm && !m_prev_arm;
    m_prev_arm = arm;
    e_valid = '0;
    e_conf  = 0;
    if (m_cast) begin
      m_cast = 0; m_locked = 1;
    end else if (m_locked) begin
      if (m_deb == 4'b0) begin m_locked = 0; e_led = 0; end
    end else if (m_armed) begin
      if (mode) m_armed = 0;
      else if (np == 1) begin m_armed = 0; m_cast = 1; e_valid = p; e_led = 1; end
      else if (np >= 2) e_conf = 1;
    end else if (rise && !mode) begin
      m_armed = 1;
    end
    e_ready = m_armed;
    // Synchronised sample is the raw value two clocks old; a level is accepted
    // once D+1 consecutive synchronised samples all disagree with it.
    hist.push_front(btn);
    void'(hist.pop_back());
    nd = m_deb;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1;
      for (int j = 2; j <= 2 + int'(D); j++) if (hist[j][b] == m_deb[b]) all_diff = 0;
      if (all_diff) nd[b] = ~m_deb[b];
    end
    m_press = nd & ~m_deb;
    m_deb   = nd;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_arm();
    arm = 1'b1; cycles(2); arm = 1'b0; cycles(1);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    btn = m; cycles(hold); btn = 4'b0;
  endtask

  task automatic settle();
    cycles(int'(D) + 8);
    mode = 1'b1; cycles(2); mode = 1'b0; cycles(1);
  endtask

  function automatic int total_pulses();
    return p_cnt[0] + p_cnt[1] + p_cnt[2] + p_cnt[3];
  endfunction

  initial begin
    int  snap [4];
    int  snap_conf;
    int  snap_tot;
    bit  got;
    logic [3:0] rmask;

    vecs[0] = '{1, 0, 4'b0010,  8, 4'b0010, 0};
    vecs[1] = '{1, 0, 4'b0001,  3, 4'b0000, 0};
    vecs[2] = '{1, 0, 4'b1100,  8, 4'b0000, 1};
    vecs[3] = '{0, 0, 4'b0001,  8, 4'b0000, 0};
    vecs[4] = '{1, 1, 4'b0100,  8, 4'b0000, 0};
    vecs[5] = '{1, 0, 4'b1000,  6, 4'b1000, 0};
    vecs[6] = '{1, 0, 4'b0001,  5, 4'b0001, 0};
    vecs[7] = '{1, 0, 4'b0100, 20, 4'b0100, 0};

    reset_n = 1'b0; mode = 1'b0; arm = 1'b0; btn = 4'b0;
    for (int k = 0; k < 4; k++) p_cnt[k] = 0;
    p_conf = 0;
    model_clear();

    fork
      forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) model_clear();
        else model_step();
      end
      forever begin
        @(negedge clock);
        chk("cycle", 32'({w_valid, ballot_ready, vote_cast_led, conflict_err}),
                     32'({e_valid, e_ready, e_led, e_conf}));
        for (int k = 0; k < 4; k++) p_cnt[k] += int'(w_valid[k]);
        p_conf += int'(conflict_err);
      end
    join_none

    cycles(3);
    chk("reset_outs", 32'({w_valid, ballot_ready, vote_cast_led, conflict_err}), 32'(0));
    reset_n = 1'b1;
    cycles(2);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) snap[k] = p_cnt[k];
      snap_conf = p_conf;
      mode = vecs[i].mode_v;
      if (vecs[i].do_arm) do_arm();
      cycles(1);
      press(vecs[i].mask, vecs[i].hold);
      settle();
      for (int k = 0; k < 4; k++)
        chk($sformatf("vec%0d_cand%0d", i, k + 1), 32'(p_cnt[k] - snap[k]),
            32'(vecs[i].exp_cand[k] ? 1 : 0));
      chk($sformatf("vec%0d_conflict", i), 32'(p_conf - snap_conf), 32'(vecs[i].exp_conf));
    end

    // Glitch while armed is ignored, a proper press afterwards votes
    do_arm();
    press(4'b0001, 3);
    cycles(10);
    chk("glitch_still_armed", 32'(ballot_ready), 32'(1));
    snap[0] = p_cnt[0];
    press(4'b0001, 6);
    cycles(12);
    chk("after_glitch_vote", 32'(p_cnt[0] - snap[0]), 32'(1));

    // No re-arm: repeated presses are locked out
    snap_tot = total_pulses();
    for (int r = 0; r < 5; r++) begin
      press(4'b0001, 8);
      cycles(10);
    end
    chk("locked_no_vote", 32'(total_pulses() - snap_tot), 32'(0));
    do_arm();
    snap[0] = p_cnt[0];
    press(4'b0001, 8);
    cycles(12);
    chk("rearm_vote", 32'(p_cnt[0] - snap[0]), 32'(1));

    // Mode switch cancels the ballot; arming in display mode is ignored
    do_arm();
    chk("armed_ready", 32'(ballot_ready), 32'(1));
    mode = 1'b1;
    cycles(1);
    chk("mode_cancel_ready", 32'(ballot_ready), 32'(0));
    snap_tot = total_pulses();
    press(4'b0010, 8);
    cycles(10);
    do_arm();
    chk("mode1_arm_ignored", 32'(ballot_ready), 32'(0));
    mode = 1'b0;
    cycles(3);
    chk("mode0_no_rearm", 32'(ballot_ready), 32'(0));
    chk("mode1_no_vote", 32'(total_pulses() - snap_tot), 32'(0));

    // Button held across arming gives no vote until released and re-pressed
    btn = 4'b0100;
    cycles(10);
    do_arm();
    snap_tot = total_pulses();
    cycles(10);
    chk("held_ready", 32'(ballot_ready), 32'(1));
    chk("held_no_vote", 32'(total_pulses() - snap_tot), 32'(0));
    btn = 4'b0;
    cycles(10);
    snap[2] = p_cnt[2];
    press(4'b0100, 8);
    cycles(12);
    chk("held_then_repress", 32'(p_cnt[2] - snap[2]), 32'(1));

    // Asynchronous reset during the cast cycle
    do_arm();
    btn = 4'b0010;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (cand2_vote_valid) got = 1;
    end
    chk("cast_seen", 32'(got), 32'(1));
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outs", 32'({w_valid, ballot_ready, vote_cast_led, conflict_err}), 32'(0));
    cycles(2);
    reset_n = 1'b1;
    btn = 4'b0;
    cycles(10);
    snap_tot = total_pulses();
    press(4'b0010, 8);
    cycles(12);
    chk("post_reset_no_arm", 32'(total_pulses() - snap_tot), 32'(0));

    // Randomized phase against the model
    for (int s = 0; s < 500; s++) begin
      rmask = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      btn   = rmask;
      arm   = ($urandom_range(0, 3) == 0);
      mode  = ($urandom_range(0, 15) == 0);
      cycles($urandom_range(1, 10));
    end
    btn = 4'b0; arm = 1'b0; mode = 1'b0;
    cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
